// File: rtl/ram_burst_writer.sv
// rtl/ram_burst_writer.sv - run-time loaded register-file RAM with burst write stream and combinational read port
module ram_burst_writer #(
  parameter int k = 8,
  parameter int l = 4,
  parameter int m = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [m-1:0] start_adr,
  input  logic [m:0]   burst_len,
  input  logic         in_valid,
  input  logic [k-1:0] in_data,
  output logic         in_ready,
  input  logic [m-1:0] read_adr,
  output logic [k-1:0] data_out,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  localparam logic [m:0] LEN_MAX = (m+1)'(l);

  state_t       state, state_nx;
  logic [m-1:0] wr_adr;
  logic [m:0]   remaining;
  logic [k-1:0] mem [l];
  logic         accept_cmd;
  logic         wr_en;

  assign accept_cmd = (state == IDLE) && start && (burst_len != '0);
  assign wr_en      = (state == WRITE) && in_valid;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept_cmd) state_nx = WRITE;
      WRITE:   if (wr_en && remaining == (m+1)'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_adr    <= '0;
      remaining <= '0;
      err       <= 1'b0;
      for (int i = 0; i < l; i++) mem[i] <= '0;
    end else begin
      state <= state_nx;
      err   <= (state == IDLE) && start && (burst_len == '0);
      // Oversized bursts are clamped so a burst never laps the memory.
      if (accept_cmd) begin
        wr_adr    <= start_adr;
        remaining <= (burst_len > LEN_MAX) ? LEN_MAX : burst_len;
      end
      if (wr_en) begin
        mem[wr_adr] <= in_data;
        wr_adr      <= wr_adr + m'(1);
        remaining   <= remaining - (m+1)'(1);
      end
    end
  end

  assign in_ready = (state == WRITE);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign data_out = mem[read_adr];

endmodule

// File: tb/tb_ram_burst_writer.sv
// tb/tb_ram_burst_writer.sv - scoreboard bench for ram_burst_writer with a queue-based reference model
module tb_ram_burst_writer;

  localparam int K = 8;
  localparam int L = 4;
  localparam int M = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [M-1:0] start_adr;
  logic [M:0]   burst_len;
  logic         in_valid;
  logic [K-1:0] in_data;
  logic         in_ready;
  logic [M-1:0] read_adr;
  logic [K-1:0] data_out;
  logic         busy, done, err;

  ram_burst_writer #(.k(K), .l(L), .m(M)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_adr(start_adr),
    .burst_len(burst_len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .read_adr(read_adr), .data_out(data_out),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_err; int cyc; } ev_t;
  ev_t          expq[$];
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [K-1:0] model [L];
  logic [K-1:0] wd [L];
  int           st [L];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done/err pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (done === 1'b1 || err === 1'b1) begin
      ev_t e;
      if (expq.size() == 0) begin
        chk("unexpected_pulse", {done, err}, 2'b00);
      end else begin
        e = expq.pop_front();
        chk("pulse_kind", {done, err}, e.is_err ? 2'b01 : 2'b10);
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic check_mem(input string name);
    for (int a = 0; a < L; a++) begin
      read_adr = M'(a);
      #1;
      chk(name, data_out, model[a]);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    start    = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < L; a++) model[a] = '0;
    chk("rst_flags", {in_ready, busy, done, err}, 4'b0000);
    check_mem("rst_mem");
  endtask

  // One command. abort_at < n stops after that many words with a reset;
  // ign pulses a second start while the first burst is writing.
  task automatic burst(input int adr, input int len, input int abort_at, input bit ign, input bit fixed);
    int n, s, tot, a;
    ev_t e;
    n = (len > L) ? L : len;
    if (!fixed)
      for (int i = 0; i < L; i++) begin
        wd[i] = K'($urandom);
        st[i] = $urandom_range(0, 2);
      end
    @(negedge clk);
    start     = 1'b1;
    start_adr = M'(adr);
    burst_len = (M+1)'(len);
    s = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    if (len == 0) begin
      e.is_err = 1'b1; e.cyc = s;
      expq.push_back(e);
      chk("zero_len_ready", in_ready, 1'b0);
      @(negedge clk);
      chk("zero_len_idle", {in_ready, busy}, 2'b00);
      return;
    end
    chk("start_ready_busy", {in_ready, busy}, 2'b11);
    tot = 0;
    for (int i = 0; i < n; i++) tot += st[i];
    if (abort_at >= n) begin
      e.is_err = 1'b0; e.cyc = s + n + tot;
      expq.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        do_reset(2);
        return;
      end
      a = (adr + i) % L;
      repeat (st[i]) begin
        in_valid = 1'b0;
        @(negedge clk);
        chk("stall_busy", {busy, in_ready, done}, 3'b110);
      end
      in_valid = 1'b1;
      in_data  = wd[i];
      read_adr = M'(a);
      if (ign && i == 1) begin
        start     = 1'b1;
        start_adr = M'(adr + 2);
        burst_len = (M+1)'(1);
      end
      #1;
      chk("ready_for_word", in_ready, 1'b1);
      chk("raw_old_value", data_out, model[a]);
      model[a] = wd[i];
      @(negedge clk);
      start = 1'b0;
      chk("raw_new_value", data_out, model[a]);
    end
    in_valid = 1'b1;
    in_data  = K'($urandom);
    #1;
    chk("done_not_ready", {in_ready, busy}, 2'b01);
    @(negedge clk);
    in_valid = 1'b0;
    chk("back_to_idle", {in_ready, busy}, 2'b00);
    check_mem("burst_mem");
  endtask

  initial begin
    start = 1'b0; start_adr = '0; burst_len = '0;
    in_valid = 1'b0; in_data = '0; read_adr = '0;
    do_reset(2);

    burst($urandom_range(0, 3), $urandom_range(1, 4), 99, 1'b0, 1'b0);
    do_reset(2);

    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;
    st[0] = 0; st[1] = 0; st[2] = 0; st[3] = 0;
    burst(0, 4, 99, 1'b0, 1'b1);

    wd[0] = 8'hAA; wd[1] = 8'hBB; st[0] = 0; st[1] = 3;
    burst(3, 2, 99, 1'b0, 1'b1);

    burst(2, 0, 99, 1'b0, 1'b0);
    check_mem("zero_len_mem");

    burst($urandom_range(0, 3), 7, 99, 1'b0, 1'b0);

    burst(1, 4, 2, 1'b0, 1'b0);

    burst(2, 4, 99, 1'b1, 1'b0);

    wd[0] = 8'h5A; st[0] = 0;
    burst(1, 1, 99, 1'b0, 1'b1);

    for (int t = 0; t < 20; t++)
      burst($urandom_range(0, 3), $urandom_range(0, 7), 99, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("events_outstanding", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_burst_writer.md
# ram_burst_writer

Write-side companion to the fixed-content lookup memory. It holds a small register-file RAM with the same combinational read port and width/depth parameters. Unlike the lookup memory, its contents are loaded at run time. A start command gives a start address and a burst length; data words then arrive on a valid/ready stream and are written to consecutive addresses. Busy/done status lets the controlling logic sequence reads after a load completes.

## Interface
Parameters:
- k, 8, data word width
- l, 4, memory depth in words; must equal 2**m
- m, 2, address width

Ports:
- clk, input, 1, rising-edge clock for all state
- rst_n, input, 1, synchronous active-low reset
- start, input, 1, command strobe; sampled only in IDLE
- start_adr, input, m, first write address of the burst
- burst_len, input, m+1, number of words to write (1..l)
- in_valid, input, 1, in_data holds a valid word
- in_data, input, k, write data word
- in_ready, output, 1, block accepts a word this cycle
- read_adr, input, m, read address
- data_out, output, k, combinational read data, mem[read_adr]
- busy, output, 1, burst in progress (WRITE or DONE state)
- done, output, 1, one-cycle pulse when the last word of a burst has been written
- err, output, 1, one-cycle pulse when a start command with burst_len==0 is rejected

## Operation
- FSM states: IDLE, WRITE, DONE.
- **IDLE:** in_ready=0, busy=0.
  - start=1 with burst_len!=0: latch wr_adr<=start_adr, remaining<=min(burst_len, l), then go to WRITE.
  - start=1 with burst_len==0: err=1 on the next cycle; stay in IDLE.
- **WRITE:** in_ready=1, busy=1.
  - A handshake is in_valid && in_ready on a rising edge.
  - On each handshake: mem[wr_adr]<=in_data; wr_adr<=wr_adr+1 modulo 2**m (wraps l-1 -> 0); remaining<=remaining-1.
  - A handshake with remaining==1 moves the FSM to DONE.
  - in_valid=0 stalls indefinitely with no state change.
- **DONE:** done=1, busy=1, in_ready=0. Next cycle goes to IDLE unconditionally.
- start is ignored while in WRITE or DONE; no queuing.
- burst_len>l is clamped to l. A burst is never longer than the memory.
- A burst starting mid-memory wraps, e.g. start_adr=3, len=2 writes addresses 3 then 0.
- Read port: data_out=mem[read_adr], combinational, available in every state.
  - A write on edge N becomes visible on data_out after edge N.
  - A same-cycle read of the address being written returns the old value.
- in_data is not checked; any k-bit value is stored verbatim.

## Timing
- Reset: rst_n low at a rising edge produces state=IDLE, wr_adr=0, remaining=0, in_ready=0, busy=0, done=0, err=0.
  - The same edge clears every mem entry to 0, so data_out=0 for all addresses after reset.
- Reset mid-burst: the burst is aborted, done is not pulsed, and memory is cleared. Reset has priority over every other input.
- Latency from start:
  - start at edge S: in_ready=1 and busy=1 from after S.
  - First word can be accepted at edge S+1.
- Throughput: one word per cycle while in_valid stays high. A burst of n words with no stalls ends with done high during cycle S+n+1 (after the edge S+n, where the last word is written), and IDLE returns after edge S+n+1.
- Minimum command-to-command spacing is n+2 cycles. A start during the done cycle is ignored.
- err is registered: high for exactly the cycle after the rejected start.
- Outputs in_ready, busy, done and err are driven directly from registered state (no combinational path from inputs). data_out is the only combinational output.

## Test plan
- **Reset:** hold rst_n=0 for 2 cycles after random prior writes -> data_out=0 for read_adr 0..3; in_ready=busy=done=err=0.
- **Full burst:** start_adr=0, len=4, words 8'h11, 22, 33, 44 with in_valid held high -> done pulses exactly one cycle, 5 cycles after start; reads of 0..3 return 11, 22, 33, 44.
- **Wrap and stall:** start_adr=3, len=2; drive in_valid low for 3 cycles between the words AA and BB -> mem[3]=AA, mem[0]=BB, others unchanged; busy stays high through the stall.
- **Zero length and clamp:**
  - len=0 -> err pulses one cycle, in_ready stays 0, memory unchanged.
  - len=7 -> exactly 4 writes, then done.
- **Reset and ignored start:**
  - Assert rst_n=0 after 2 of 4 words -> no done pulse, all entries 0, FSM in IDLE.
  - start pulsed during WRITE -> ignored; the original burst completes.
- **Read-after-write:** read_adr=1 while writing 8'h5A to address 1 -> old value in the write cycle, 5A from the next cycle on.
